// File: rtl/param_sync_counter.sv
// param_sync_counter: up/down counter, 0..MAX_VAL, wrap or saturate.
// Limit events raise a one-cycle wrap pulse and a sticky ovf flag.
//
// Ports:
//   clock    in   rising-edge clock
//   clear    in   sync active-high reset
//   cnt_en   in   count enable
//   up_dn    in   1 = up, 0 = down
//   load     in   parallel load strobe
//   load_val in   load value (clamped to MAX_VAL)
//   ovf_clr  in   clears sticky ovf
//   q        out  registered count
//   tc       out  comb terminal count
//   wrap     out  registered limit pulse
//   ovf      out  registered sticky limit flag
module param_sync_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX =
    MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  logic             at_max;
  logic             at_zero;
  logic             evt;
  logic [WIDTH-1:0] ld_clamp;
  logic [WIDTH-1:0] q_nxt;

  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);

  assign tc = cnt_en &
              ((up_dn & at_max) |
               (~up_dn & at_zero));

  // A load masks any count, so it
  // can never produce a limit event.
  assign evt = tc & ~load;

  assign ld_clamp = (load_val > MAX) ?
                    MAX : load_val;

  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = ld_clamp;
    end else if (cnt_en) begin
      unique case (1'b1)
        up_dn & ~at_max:
          q_nxt = q + ONE;
        ~up_dn & ~at_zero:
          q_nxt = q - ONE;
        up_dn & at_max:
          q_nxt = SATURATE ? MAX : '0;
        default:
          q_nxt = SATURATE ? '0 : MAX;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= evt;
      // Set beats ovf_clr on the same edge.
      if (evt)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_sync_counter.sv
// tb_param_sync_counter: four counter variants against an
// arithmetic reference model, directed plus random stimulus.
module tb_param_sync_counter;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       cnt_en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       ovf_clr = 1'b0;

  logic [3:0] q_a, q_b;
  logic [7:0] q_c, q_d;
  logic tc_a, tc_b, tc_c, tc_d;
  logic wr_a, wr_b, wr_c, wr_d;
  logic ov_a, ov_b, ov_c, ov_d;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  // A: W4 M9 wrap, B: W4 M9 sat,
  // C: W8 M255 wrap, D: W8 M255 sat
  param_sync_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)
  ) u_a (
    .clock(clock), .clear(clear),
    .cnt_en(cnt_en), .up_dn(up_dn),
    .load(load), .load_val(load_val[3:0]),
    .ovf_clr(ovf_clr), .q(q_a), .tc(tc_a),
    .wrap(wr_a), .ovf(ov_a)
  );

  param_sync_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)
  ) u_b (
    .clock(clock), .clear(clear),
    .cnt_en(cnt_en), .up_dn(up_dn),
    .load(load), .load_val(load_val[3:0]),
    .ovf_clr(ovf_clr), .q(q_b), .tc(tc_b),
    .wrap(wr_b), .ovf(ov_b)
  );

  param_sync_counter #(
    .WIDTH(8), .SATURATE(1'b0)
  ) u_c (
    .clock(clock), .clear(clear),
    .cnt_en(cnt_en), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q_c), .tc(tc_c),
    .wrap(wr_c), .ovf(ov_c)
  );

  param_sync_counter #(
    .WIDTH(8), .SATURATE(1'b1)
  ) u_d (
    .clock(clock), .clear(clear),
    .cnt_en(cnt_en), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q_d), .tc(tc_d),
    .wrap(wr_d), .ovf(ov_d)
  );

  // Reference model: plain integer arithmetic.
  int mx[4] = '{9, 9, 255, 255};
  int mm[4] = '{15, 15, 255, 255};
  int ms[4] = '{0, 1, 0, 1};
  int mq[4] = '{0, 0, 0, 0};
  int mw[4] = '{0, 0, 0, 0};
  int mo[4] = '{0, 0, 0, 0};
  bit mv = 1'b0;

  always @(posedge clock) begin
    int nq, nw, nov, lv;
    for (int k = 0; k < 4; k++) begin
      nq = mq[k];
      nw = 0;
      nov = mo[k];
      lv = int'(load_val) & mm[k];
      if (clear) begin
        nq = 0;
        nov = 0;
      end else if (load) begin
        nq = (lv > mx[k]) ? mx[k] : lv;
      end else if (cnt_en && up_dn) begin
        if (mq[k] == mx[k]) begin
          nw = 1;
          nq = ms[k] ? mx[k] : 0;
        end else begin
          nq = mq[k] + 1;
        end
      end else if (cnt_en) begin
        if (mq[k] == 0) begin
          nw = 1;
          nq = ms[k] ? 0 : mx[k];
        end else begin
          nq = mq[k] - 1;
        end
      end
      if (!clear)
        nov = nw ? 1 : (ovf_clr ? 0 : mo[k]);
      mq[k] <= nq;
      mw[k] <= nw;
      mo[k] <= nov;
    end
    if (clear)
      mv <= 1'b1;
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic cmp(input int k, input int q,
                     input int w, input int o,
                     input int t);
    int et;
    et = (cnt_en && ((up_dn && mq[k] == mx[k]) ||
          (!up_dn && mq[k] == 0))) ? 1 : 0;
    chk($sformatf("m%0d_q", k), q, mq[k]);
    chk($sformatf("m%0d_wrap", k), w, mw[k]);
    chk($sformatf("m%0d_ovf", k), o, mo[k]);
    chk($sformatf("m%0d_tc", k), t, et);
    chk($sformatf("m%0d_qmax", k),
        (q <= mx[k]) ? 1 : 0, 1);
  endtask

  always @(negedge clock) begin
    if (mv) begin
      cmp(0, int'(q_a), int'(wr_a),
          int'(ov_a), int'(tc_a));
      cmp(1, int'(q_b), int'(wr_b),
          int'(ov_b), int'(tc_b));
      cmp(2, int'(q_c), int'(wr_c),
          int'(ov_c), int'(tc_c));
      cmp(3, int'(q_d), int'(wr_d),
          int'(ov_d), int'(tc_d));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; cnt_en = 1'b0;
    up_dn = 1'b0; load = 1'b0;
    load_val = '0; ovf_clr = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int eq;
    // Reset and up-count with wrap
    idle();
    clear = 1'b1;
    repeat (3) tick();
    chk("rst_q", int'(q_a), 0);
    chk("rst_wrap", int'(wr_a), 0);
    chk("rst_ovf", int'(ov_a), 0);
    clear = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      eq = i % 10;
      chk("up_q", int'(q_a), eq);
      chk("up_wrap", int'(wr_a), (i == 10) ? 1 : 0);
      chk("up_ovf", int'(ov_a), (i >= 10) ? 1 : 0);
      chk("up_tc", int'(tc_a), (eq == 9) ? 1 : 0);
    end

    // Saturating hold after load 7
    do_clear();
    load = 1'b1; load_val = 8'd7;
    tick();
    chk("sat_ld", int'(q_b), 7);
    load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_q", int'(q_b), (i >= 2) ? 9 : 7 + i);
      chk("sat_wrap", int'(wr_b), (i >= 3) ? 1 : 0);
    end
    chk("sat_ovf", int'(ov_b), 1);

    // Clamped load then wrap
    do_clear();
    load = 1'b1; load_val = 8'd14;
    cnt_en = 1'b1; up_dn = 1'b1;
    tick();
    chk("clamp_q", int'(q_a), 9);
    chk("clamp_wrap", int'(wr_a), 0);
    chk("clamp_c", int'(q_c), 14);
    load = 1'b0;
    tick();
    chk("clamp_nq", int'(q_a), 0);
    chk("clamp_nwrap", int'(wr_a), 1);

    // Down wrap with ovf_clr race
    do_clear();
    cnt_en = 1'b1; up_dn = 1'b0; ovf_clr = 1'b1;
    tick();
    chk("dn_q", int'(q_a), 9);
    chk("dn_wrap", int'(wr_a), 1);
    chk("dn_ovf_set", int'(ov_a), 1);
    cnt_en = 1'b0;
    tick();
    chk("dn_ovf_clr", int'(ov_a), 0);
    chk("dn_hold", int'(q_a), 9);
    chk("dn_wrap0", int'(wr_a), 0);

    // Clear beats load mid-count
    do_clear();
    load = 1'b1; load_val = 8'd5;
    tick();
    chk("cl_ld", int'(q_a), 5);
    load_val = 8'd3; cnt_en = 1'b1;
    up_dn = 1'b1; clear = 1'b1;
    tick();
    chk("cl_q", int'(q_a), 0);
    chk("cl_ovf", int'(ov_a), 0);
    chk("cl_wrap", int'(wr_a), 0);
    clear = 1'b0; load = 1'b0;
    tick();
    chk("cl_next", int'(q_a), 1);

    // Random stimulus
    do_clear();
    for (int i = 0; i < 2000; i++) begin
      clear    = ($urandom_range(0, 199) == 0);
      cnt_en   = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      ovf_clr  = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    @(negedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_sync_counter.md
PARAM_SYNC_COUNTER -- requirements
Module: param_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (SHALL be >= 2).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, top count value, 1 <= MAX_VAL <= 2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 clear  input  1  synchronous, active-high reset.
REQ-006 cnt_en  input  1  count enable.
REQ-007 up_dn  input  1  direction; 1 = up, 0 = down.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 ovf_clr  input  1  clears sticky overflow flag.
REQ-011 q  output  WIDTH  registered count.
REQ-012 tc  output  1  combinational terminal count.
REQ-013 wrap  output  1  registered one-cycle limit-event pulse.
REQ-014 ovf  output  1  registered sticky limit-event flag.

Function
REQ-015 Update priority per edge SHALL be: clear > load > count > hold.
REQ-016 load=1 SHALL set q to load_val, or to MAX_VAL if load_val > MAX_VAL, regardless of cnt_en/up_dn; no limit event.
REQ-017 cnt_en=1, load=0, up_dn=1, q < MAX_VAL: q SHALL become q+1 next edge.
REQ-018 cnt_en=1, load=0, up_dn=0, q > 0: q SHALL become q-1 next edge.
REQ-019 Up-count at q==MAX_VAL SHALL be a limit event: q -> 0 if SATURATE=0, q held at MAX_VAL if SATURATE=1.
REQ-020 Down-count at q==0 SHALL be a limit event: q -> MAX_VAL if SATURATE=0, q held at 0 if SATURATE=1.
REQ-021 cnt_en=0, load=0: q SHALL hold; no event.
REQ-022 q SHALL never exceed MAX_VAL after any edge with clear=0.
REQ-023 tc SHALL equal cnt_en & ((up_dn & q==MAX_VAL) | (~up_dn & q==0)), zero-latency.
REQ-024 wrap SHALL be 1 for exactly the cycle after each limit event edge, else 0; back-to-back events (SATURATE=1, held enable) SHALL keep wrap high each cycle.
REQ-025 ovf SHALL set on the edge of any limit event and stay set until clear or ovf_clr.
REQ-026 ovf_clr and a limit event on the same edge: set SHALL win (ovf=1).
REQ-027 Direction change mid-count SHALL take effect on the next enabled edge with no skipped or repeated value.
REQ-028 All arithmetic SHALL be WIDTH-bit; no internal wider state observable.

Reset
REQ-029 clear=1 at an edge SHALL force q=0, wrap=0, ovf=0, overriding load, cnt_en, ovf_clr.
REQ-030 Before the first clear, outputs are undefined; clear asserted mid-count SHALL take effect on that edge with no partial update.
REQ-031 First enabled count after clear deassertion SHALL occur on the first edge with clear=0.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-032 clear 3 cycles, cnt_en=1, up_dn=1, SATURATE=0, 12 edges -> q 1..9,0,1,2; wrap high only the cycle after 9->0; ovf=1 thereafter; tc=1 while q==9.
REQ-033 SATURATE=1, load_val=7, load 1 cycle, then count up 5 edges -> q 8,9,9,9,9; wrap high 3 consecutive cycles; ovf=1.
REQ-034 load_val=14 with load=1 and cnt_en=1 -> q=9 (clamped), no wrap; next up edge (SATURATE=0) -> q=0, wrap=1.
REQ-035 q=0, up_dn=0, SATURATE=0, one edge -> q=9, wrap=1; ovf_clr=1 concurrent with that event -> ovf=1; ovf_clr alone next edge -> ovf=0.
REQ-036 Counting at q=5 with load=1 and clear=1 same edge -> q=0, ovf=0, wrap=0; q increments on the next edge after clear drops.
REQ-037 Random cnt_en/up_dn/load stimulus 2000 cycles, WIDTH=8 default MAX_VAL, both SATURATE values -> q matches a reference model every cycle.
